// File: rtl/io_pkg.sv
// Shared address map and sizing for the memory-mapped I/O blocks on the CPU data bus.
package io_pkg;

  localparam logic [31:0] IO_ADDR_LEDS     = 32'd0;
  localparam logic [31:0] IO_ADDR_SOUND_L  = 32'd3;
  localparam logic [31:0] IO_ADDR_SOUND_R  = 32'd7;
  localparam logic [31:0] IO_ADDR_RGB0     = 32'd11;
  localparam logic [31:0] IO_ADDR_RGB1     = 32'd15;
  localparam logic [31:0] IO_ADDR_IN_LEVEL = 32'd19;
  localparam logic [31:0] IO_ADDR_IN_RISE  = 32'd23;

  localparam int unsigned IO_N_INPUTS = 19;

  // Bus operation decoded by the input block.
  typedef enum logic [1:0] {
    BusIdle,
    BusReadLevel,
    BusReadRise,
    BusOther
  } io_in_rd_sel_e;

  function automatic io_in_rd_sel_e io_in_decode_rd(input logic        read_en,
                                                    input logic [31:0] addr);
    io_in_rd_sel_e sel;
    sel = BusIdle;
    if (read_en) begin
      if (addr == IO_ADDR_IN_LEVEL) begin
        sel = BusReadLevel;
      end else if (addr == IO_ADDR_IN_RISE) begin
        sel = BusReadRise;
      end else begin
        sel = BusOther;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/io_input_debounce.sv
// Vector-wide 2-flop synchroniser, shared sample tick, 3-deep history and debounced level.
module io_input_debounce
  import io_pkg::*;
#(
  parameter int unsigned N_INPUTS        = IO_N_INPUTS,
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter int unsigned CNT_W           = 17
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [N_INPUTS-1:0] raw_i,
  output logic [N_INPUTS-1:0] deb_o
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_INPUTS-1:0]      sync1_q, sync2_q;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     tick;
  logic [2:0][N_INPUTS-1:0] hist_q, hist_d;
  logic [N_INPUTS-1:0]      deb_q, deb_d;
  logic [N_INPUTS-1:0]      all_ones, all_zeros;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // With DEBOUNCE_CYCLES == 1 CntMax is 0, so tick stays high every cycle.
  always_comb begin
    tick  = (cnt_q == CntMax);
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
  end

  always_comb begin
    hist_d = hist_q;
    if (tick) begin
      hist_d = {hist_q[1:0], sync2_q};
    end
  end

  // Level follows history only when all three samples agree; otherwise it holds.
  always_comb begin
    all_ones  = hist_q[0] & hist_q[1] & hist_q[2];
    all_zeros = ~(hist_q[0] | hist_q[1] | hist_q[2]);
    deb_d     = all_ones | (deb_q & ~all_zeros);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      hist_q <= '0;
      deb_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      hist_q <= hist_d;
      deb_q  <= deb_d;
    end
  end

  assign deb_o = deb_q;

endmodule

// File: rtl/io_input_block.sv
// Debounced switch/button inputs with sticky rise flags, W1C clear, load mux and level IRQ.
module io_input_block
  import io_pkg::*;
#(
  parameter int unsigned N_INPUTS        = IO_N_INPUTS,
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter int unsigned CNT_W           = 17
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_INPUTS-1:0] switches_and_buttons,
  input  logic                read_en,
  input  logic                write_en,
  input  logic [31:0]         addr,
  input  logic [31:0]         wr_data,
  output logic [31:0]         rd_data,
  output logic                io_vld,
  output logic                irq
);

  logic [N_INPUTS-1:0] deb;
  logic [N_INPUTS-1:0] deb_prev_q;
  logic [N_INPUTS-1:0] rise_q, rise_d;
  logic [N_INPUTS-1:0] rise_set, rise_clr;
  logic                irq_q, irq_d;
  io_in_rd_sel_e       rd_sel;

  io_input_debounce #(
    .N_INPUTS       (N_INPUTS),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_debounce (
    .clk_i (clk),
    .rst_ni(rst),
    .raw_i (switches_and_buttons),
    .deb_o (deb)
  );

  // A set in the same cycle as its clear wins, so set is OR-ed in after masking.
  always_comb begin
    rise_set = deb & ~deb_prev_q;
    rise_clr = '0;
    if (write_en && (addr == IO_ADDR_IN_RISE)) begin
      rise_clr = wr_data[N_INPUTS-1:0];
    end
    rise_d = (rise_q & ~rise_clr) | rise_set;
    irq_d  = |rise_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb_prev_q <= '0;
      rise_q     <= '0;
      irq_q      <= 1'b0;
    end else begin
      deb_prev_q <= deb;
      rise_q     <= rise_d;
      irq_q      <= irq_d;
    end
  end

  assign irq = irq_q;

  always_comb begin
    rd_sel  = io_in_decode_rd(read_en, addr);
    rd_data = '0;
    io_vld  = 1'b0;
    unique case (rd_sel)
      BusReadLevel: begin
        rd_data[N_INPUTS-1:0] = deb;
        io_vld                = 1'b1;
      end
      BusReadRise: begin
        rd_data[N_INPUTS-1:0] = rise_q;
        io_vld                = 1'b1;
      end
      BusIdle, BusOther: begin
        rd_data = '0;
        io_vld  = 1'b0;
      end
      default: begin
        rd_data = '0;
        io_vld  = 1'b0;
      end
    endcase
  end

  if (N_INPUTS < 32) begin : g_unused_wr_data
    logic unused_wr_data_hi;
    assign unused_wr_data_hi = ^wr_data[31:N_INPUTS];
  end

endmodule

// File: tb/tb_io_input_block.sv
// Directed bench for io_input_block with a 4-cycle debounce tick.
module tb_io_input_block;
  import io_pkg::*;

  localparam int unsigned NIn = 19;

  logic            clk = 1'b0;
  logic            rst;
  logic [NIn-1:0]  sw;
  logic            read_en, write_en;
  logic [31:0]     addr, wr_data, rd_data;
  logic            io_vld, irq;

  int unsigned n_checks;
  int unsigned n_fail;

  always #5 clk = ~clk;

  io_input_block #(
    .N_INPUTS       (NIn),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .switches_and_buttons(sw),
    .read_en             (read_en),
    .write_en            (write_en),
    .addr                (addr),
    .wr_data             (wr_data),
    .rd_data             (rd_data),
    .io_vld              (io_vld),
    .irq                 (irq)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d, output logic v);
    read_en = 1'b1;
    addr    = a;
    #1;
    d       = rd_data;
    v       = io_vld;
    read_en = 1'b0;
    addr    = '0;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    write_en = 1'b1;
    addr     = a;
    wr_data  = d;
    step();
    write_en = 1'b0;
    addr     = '0;
    wr_data  = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d;
    logic        v;
    int          n;
    bit          seen;

    n_checks = 0;
    n_fail   = 0;
    read_en  = 1'b0;
    write_en = 1'b0;
    addr     = '0;
    wr_data  = '0;
    rst      = 1'b0;
    sw       = '1;

    // Reset with all inputs high, then release and watch them come through.
    steps(3);
    bus_rd(IO_ADDR_IN_LEVEL, d, v);
    check_eq("in_reset_level", d, 32'h0);
    check_eq("in_reset_irq", {31'b0, irq}, 32'h0);
    rst = 1'b1;
    bus_rd(IO_ADDR_IN_LEVEL, d, v);
    check_eq("rel_level_now", d, 32'h0);
    check_eq("rel_level_vld", {31'b0, v}, 32'h1);
    bus_rd(IO_ADDR_IN_RISE, d, v);
    check_eq("rel_rise_now", d, 32'h0);
    steps(12);
    bus_rd(IO_ADDR_IN_LEVEL, d, v);
    check_eq("rel_level_c12", d, 32'h0);
    steps(5);
    bus_rd(IO_ADDR_IN_LEVEL, d, v);
    check_eq("rel_level_c17", d, 32'h7FFFF);
    bus_rd(IO_ADDR_IN_RISE, d, v);
    check_eq("rel_rise_c17", d, 32'h7FFFF);
    check_eq("rel_irq_c17", {31'b0, irq}, 32'h1);

    // Falling levels set nothing; then clear everything.
    sw = '0;
    steps(20);
    bus_rd(IO_ADDR_IN_LEVEL, d, v);
    check_eq("fall_level", d, 32'h0);
    bus_rd(IO_ADDR_IN_RISE, d, v);
    check_eq("fall_rise_kept", d, 32'h7FFFF);
    bus_wr(IO_ADDR_IN_RISE, 32'hFFFF_FFFF);
    bus_rd(IO_ADDR_IN_RISE, d, v);
    check_eq("clr_all_rise", d, 32'h0);
    step();
    check_eq("clr_all_irq", {31'b0, irq}, 32'h0);

    // Clean step on bit 5.
    sw[5] = 1'b1;
    seen  = 1'b0;
    n     = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      bus_rd(IO_ADDR_IN_LEVEL, d, v);
      if (d[5]) begin
        seen = 1'b1;
        n    = i;
        bus_rd(IO_ADDR_IN_RISE, d, v);
        check_eq("b5_rise_same_cycle", d, 32'h0);
        break;
      end
    end
    check_eq("b5_latency_12_15", {31'b0, (seen && n >= 12 && n <= 15)}, 32'h1);
    step();
    bus_rd(IO_ADDR_IN_RISE, d, v);
    check_eq("b5_rise_next", d, 32'h20);
    check_eq("b5_irq_not_yet", {31'b0, irq}, 32'h0);
    step();
    check_eq("b5_irq", {31'b0, irq}, 32'h1);
    bus_wr(IO_ADDR_IN_RISE, 32'h20);
    steps(2);

    // Glitch on bit 0 spanning at most two ticks.
    sw[0] = 1'b1;
    steps(5);
    sw[0] = 1'b0;
    steps(20);
    bus_rd(IO_ADDR_IN_LEVEL, d, v);
    check_eq("glitch_level", d, 32'h20);
    bus_rd(IO_ADDR_IN_RISE, d, v);
    check_eq("glitch_rise", d, 32'h0);
    check_eq("glitch_irq", {31'b0, irq}, 32'h0);

    // W1C on a two-bit flag set.
    sw = '0;
    steps(20);
    sw = 19'h00021;
    steps(20);
    bus_rd(IO_ADDR_IN_RISE, d, v);
    check_eq("w1c_start", d, 32'h21);
    bus_wr(IO_ADDR_IN_RISE, 32'h1);
    bus_rd(IO_ADDR_IN_RISE, d, v);
    check_eq("w1c_bit0", d, 32'h20);
    bus_wr(IO_ADDR_IN_RISE, 32'h20);
    bus_rd(IO_ADDR_IN_RISE, d, v);
    check_eq("w1c_bit5", d, 32'h0);
    check_eq("w1c_irq_lag", {31'b0, irq}, 32'h1);
    step();
    check_eq("w1c_irq_drop", {31'b0, irq}, 32'h0);

    // Clear of bit 3 lands in the same cycle its set fires.
    sw[3] = 1'b1;
    seen  = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      bus_rd(IO_ADDR_IN_LEVEL, d, v);
      if (d[3]) begin
        seen     = 1'b1;
        read_en  = 1'b1;
        write_en = 1'b1;
        addr     = IO_ADDR_IN_RISE;
        wr_data  = 32'h8;
        #1;
        check_eq("coll_preread", rd_data, 32'h0);
        step();
        read_en  = 1'b0;
        write_en = 1'b0;
        addr     = '0;
        wr_data  = '0;
        break;
      end
    end
    check_eq("coll_seen", {31'b0, seen}, 32'h1);
    bus_rd(IO_ADDR_IN_RISE, d, v);
    check_eq("coll_set_wins", d, 32'h8);

    // Address decode: misses and ignored writes.
    bus_rd(32'd20, d, v);
    check_eq("dec20_data", d, 32'h0);
    check_eq("dec20_vld", {31'b0, v}, 32'h0);
    bus_rd(32'h8000_0013, d, v);
    check_eq("dec_hi_data", d, 32'h0);
    check_eq("dec_hi_vld", {31'b0, v}, 32'h0);
    bus_rd(32'd0, d, v);
    check_eq("dec0_data", d, 32'h0);
    check_eq("dec0_vld", {31'b0, v}, 32'h0);
    bus_wr(IO_ADDR_IN_LEVEL, 32'hFFFF_FFFF);
    bus_wr(32'h8000_0017, 32'hFFFF_FFFF);
    bus_rd(IO_ADDR_IN_RISE, d, v);
    check_eq("dec_wr_rise", d, 32'h8);
    bus_rd(IO_ADDR_IN_LEVEL, d, v);
    check_eq("dec_wr_level", d, 32'h29);

    // Asynchronous reset mid-debounce of bit 7.
    sw = 19'h000A9;
    steps(5);
    read_en = 1'b1;
    addr    = IO_ADDR_IN_LEVEL;
    #2;
    rst = 1'b0;
    #1;
    check_eq("arst_level", rd_data, 32'h0);
    addr = IO_ADDR_IN_RISE;
    #1;
    check_eq("arst_rise", rd_data, 32'h0);
    check_eq("arst_irq", {31'b0, irq}, 32'h0);
    read_en = 1'b0;
    addr    = '0;
    @(negedge clk);
    step();
    rst = 1'b1;
    steps(20);
    bus_rd(IO_ADDR_IN_LEVEL, d, v);
    check_eq("post_rst_level", d, 32'hA9);

    // Load and clear in the same cycle returns the pre-clear flags.
    read_en  = 1'b1;
    write_en = 1'b1;
    addr     = IO_ADDR_IN_RISE;
    wr_data  = 32'hFFFF_FFFF;
    #1;
    check_eq("rdclr_data", rd_data, 32'hA9);
    check_eq("rdclr_vld", {31'b0, io_vld}, 32'h1);
    step();
    read_en  = 1'b0;
    write_en = 1'b0;
    addr     = '0;
    wr_data  = '0;
    bus_rd(IO_ADDR_IN_RISE, d, v);
    check_eq("rdclr_after", d, 32'h0);
    check_eq("rdclr_irq_lag", {31'b0, irq}, 32'h1);
    step();
    check_eq("rdclr_irq_drop", {31'b0, irq}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
